// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types, constants and helpers for bin2bcd_display.
//                Holds the FSM state encoding, the digit/step counts, the
//                largest value that fits in eight decimal digits, and the
//                leading-zero blanking mask function.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam int          CONV_STEPS = 32;
    localparam logic [31:0] DEC_MAX    = 32'd99_999_999;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    // Enable every digit from the most significant nonzero one down to
    // digit 0; digit 0 is always lit so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] blank_mask(
        input logic [NUM_DIGITS-1:0][3:0] digits
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digits[i] != 4'h0) begin
                seen = 1'b1;
            end
            mask[i] = seen;
        end
        mask[0] = 1'b1;
        return mask;
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/bcd_adj4.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_adj4
//  Description : Double-dabble digit correction. Adds 3 to a BCD digit that
//                is 5 or more so the following left shift carries into the
//                next decimal digit.
//  Ports       : i_digit - BCD digit before the shift
//                o_digit - corrected digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_adj4 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_adj4
`default_nettype wire

// File: rtl/bin2bcd_display.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_display
//  Description : Converts a 32-bit unsigned value to eight display digits,
//                either as decimal (serial double-dabble, 32 steps) or as
//                hexadecimal (single-cycle nibble load), with optional
//                leading-zero blanking and decimal-overflow indication.
//  Ports       : clk     - clock, rising edge
//                clr_n   - asynchronous active-low reset
//                start   - conversion request, sampled in IDLE only
//                mode    - 0 = decimal, 1 = hexadecimal
//                value   - operand
//                dots_in - decimal-point mask
//                display - eight digit nibbles, index 0 least significant
//                en_out  - per-digit enable
//                dots    - registered decimal-point mask
//                busy    - decimal conversion in progress
//                done    - one-cycle pulse when the outputs update
//                ovf     - last decimal request exceeded 99_999_999
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_display
    import display_pkg::*;
#(
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       start,
    input  logic                       mode,
    input  logic [31:0]                value,
    input  logic [7:0]                 dots_in,
    output logic [NUM_DIGITS-1:0][3:0] display,
    output logic [NUM_DIGITS-1:0]      en_out,
    output logic [7:0]                 dots,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf
);

    state_t                     r_state;
    logic [4:0]                 r_cnt;
    logic [31:0]                r_shift;
    logic [NUM_DIGITS-1:0][3:0] r_bcd;
    logic [7:0]                 r_dots_lat;
    logic                       r_ovf_pend;

    logic [NUM_DIGITS-1:0][3:0] w_adj;
    logic [31:0]                w_adj_flat;
    logic [NUM_DIGITS-1:0][3:0] w_bcd_next;
    logic [NUM_DIGITS-1:0][3:0] w_hex_digits;
    logic [NUM_DIGITS-1:0]      w_en_hex;
    logic [NUM_DIGITS-1:0]      w_en_dec;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            bcd_adj4 u_adj (
                .i_digit (r_bcd[gi]),
                .o_digit (w_adj[gi])
            );
        end
    endgenerate

    // Corrected digits shift left one place with the operand MSB entering
    // at bit 0; the carry out of digit 7 is dropped.
    assign w_adj_flat   = w_adj;
    assign w_bcd_next   = {w_adj_flat[30:0], r_shift[31]};
    assign w_hex_digits = value;

    assign w_en_hex = (BLANK_LEADING != 0) ? blank_mask(w_hex_digits) : {NUM_DIGITS{1'b1}};
    assign w_en_dec = (BLANK_LEADING != 0) ? blank_mask(r_bcd)        : {NUM_DIGITS{1'b1}};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_shift    <= 32'd0;
            r_bcd      <= '0;
            r_dots_lat <= 8'h00;
            r_ovf_pend <= 1'b0;
            display    <= '0;
            en_out     <= 8'h01;
            dots       <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode) begin
                            display <= w_hex_digits;
                            en_out  <= w_en_hex;
                            dots    <= dots_in;
                            ovf     <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_shift    <= value;
                            r_ovf_pend <= (value > DEC_MAX);
                            r_dots_lat <= dots_in;
                            r_bcd      <= '0;
                            r_cnt      <= 5'd0;
                            busy       <= 1'b1;
                            r_state    <= ST_CONVERT;
                        end
                    end
                end

                ST_CONVERT: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= {r_shift[30:0], 1'b0};
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'(CONV_STEPS - 1)) begin
                        r_state <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    if (r_ovf_pend) begin
                        display <= {NUM_DIGITS{4'hE}};
                        en_out  <= {NUM_DIGITS{1'b1}};
                        ovf     <= 1'b1;
                    end else begin
                        display <= r_bcd;
                        en_out  <= w_en_dec;
                        ovf     <= 1'b0;
                    end
                    dots    <= r_dots_lat;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_cnt   <= 5'd0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : bin2bcd_display
`default_nettype wire

// File: tb/tb_bin2bcd_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_display
//  Description : Self-checking bench for bin2bcd_display. Expected results
//                are built from an arithmetic model and queued when a
//                request is issued, then popped and compared on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_display;

    typedef struct {
        logic [31:0] disp;
        logic [7:0]  en;
        logic [7:0]  dts;
        logic        ov;
        int          lat;
    } exp_t;

    logic            clk;
    logic            clr_n;
    logic            start;
    logic            mode;
    logic [31:0]     value;
    logic [7:0]      dots_in;
    logic [7:0][3:0] display;
    logic [7:0]      en_out;
    logic [7:0]      dots;
    logic            busy;
    logic            done;
    logic            ovf;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    bin2bcd_display #(.BLANK_LEADING(1)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .mode    (mode),
        .value   (value),
        .dots_in (dots_in),
        .display (display),
        .en_out  (en_out),
        .dots    (dots),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: decimal digits by repeated division, hex by nibble,
    // enable mask from the highest nonzero digit downwards.
    function automatic exp_t model(input logic m, input logic [31:0] v, input logic [7:0] d);
        exp_t        e;
        logic [3:0]  dig [8];
        int unsigned rem;
        int          top;
        rem = v;
        for (int i = 0; i < 8; i++) begin
            if (m) dig[i] = v[4*i +: 4];
            else begin
                dig[i] = 4'(rem % 10);
                rem    = rem / 10;
            end
        end
        top = 0;
        for (int i = 0; i < 8; i++) if (dig[i] != 4'h0) top = i;
        e.disp = 32'h0;
        for (int i = 0; i < 8; i++) e.disp[4*i +: 4] = dig[i];
        e.en  = 8'((9'd1 << (top + 1)) - 9'd1);
        e.dts = d;
        e.ov  = 1'b0;
        e.lat = m ? 1 : 34;
        if (!m && v > 32'd99_999_999) begin
            e.disp = 32'hEEEE_EEEE;
            e.en   = 8'hFF;
            e.ov   = 1'b1;
        end
        return e;
    endfunction

    // Issue one request; optionally fire a second start mid-conversion.
    task automatic run(input logic m, input logic [31:0] v, input logic [7:0] d, input bit inject);
        exp_t        e;
        int          lat;
        logic [31:0] held;
        sb.push_back(model(m, v, d));
        @(negedge clk);
        start = 1'b1; mode = m; value = v; dots_in = d;
        @(posedge clk); #1;
        start = 1'b0; value = $urandom; dots_in = 8'($urandom); mode = 1'($urandom);
        chk("busy_after_start", {31'd0, busy}, {31'd0, ~m});
        lat = 1;
        while (!done && lat < 40) begin
            start = inject && (lat == 10);
            if (start) begin
                value = 32'd22_222_222; mode = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk("done_latency", lat, e.lat);
        chk("display", display, e.disp);
        chk("en_out", {24'd0, en_out}, {24'd0, e.en});
        chk("dots", {24'd0, dots}, {24'd0, e.dts});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        held = display;
        @(posedge clk); #1;
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("display_hold", display, held);
    endtask

    initial begin
        int seen;
        n_tests = 0;
        n_fail  = 0;
        clr_n = 1'b0; start = 1'b0; mode = 1'b0; value = 32'd0; dots_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_display", display, 32'h0);
        chk("rst_en", {24'd0, en_out}, 32'h01);
        chk("rst_dots", {24'd0, dots}, 32'h0);
        chk("rst_busy_done_ovf", {29'd0, busy, done, ovf}, 32'd0);
        @(negedge clk) clr_n = 1'b1;

        run(1'b0, 32'd12_345_678, 8'h00, 1'b0);
        run(1'b0, 32'd0,          8'h01, 1'b0);
        run(1'b0, 32'd907,        8'h02, 1'b0);
        run(1'b0, 32'hFFFF_FFFF,  8'h80, 1'b0);
        run(1'b0, 32'd99_999_999, 8'h00, 1'b0);
        run(1'b0, 32'd100_000_000, 8'h00, 1'b0);
        run(1'b1, 32'h00AB_C0DE,  8'h10, 1'b0);
        run(1'b1, 32'h0000_0000,  8'h00, 1'b0);
        run(1'b0, 32'd11_111_111, 8'h55, 1'b1);

        // Abort a conversion part-way through with reset.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; value = 32'd555; dots_in = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk) clr_n = 1'b0;
        #1;
        chk("abort_display", display, 32'h0);
        chk("abort_en", {24'd0, en_out}, 32'h01);
        chk("abort_dots", {24'd0, dots}, 32'h0);
        chk("abort_busy_done_ovf", {29'd0, busy, done, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) clr_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        run(1'b0, 32'd42, 8'h03, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bin2bcd_display
`default_nettype wire

// File: doc/bin2bcd_display.md
BIN2BCD_DISPLAY -- requirements
Module: bin2bcd_display

Interface
REQ-001 SHALL have parameter BLANK_LEADING, default 1: 1 = leading-zero digits are disabled in en_out; 0 = all 8 digits are enabled.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port clr_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request conversion of value; sampled only in IDLE.
REQ-005 SHALL have port mode, input, 1 bit: 0 = decimal (BCD), 1 = hexadecimal; sampled with start.
REQ-006 SHALL have port value, input, 32 bits: unsigned operand; sampled with start.
REQ-007 SHALL have port dots_in, input, 8 bits: decimal-point mask; sampled with start.
REQ-008 SHALL have port display, output, packed [7:0][3:0]: digit nibbles, index 0 = least significant; feeds the 8-digit screen driver.
REQ-009 SHALL have port en_out, output, 8 bits: per-digit enable for the screen driver.
REQ-010 SHALL have port dots, output, 8 bits: registered copy of dots_in.
REQ-011 SHALL have port busy, output, 1 bit: high while a decimal conversion is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when display, en_out, dots and ovf update.
REQ-013 SHALL have port ovf, output, 1 bit: the last decimal request exceeded 99_999_999.

Function
REQ-014 SHALL implement the FSM states IDLE, CONVERT and FINISH.
REQ-015 IDLE, start=1, mode=1: SHALL load display[i] = value[4i+3:4i] and dots = dots_in, set ovf=0, pulse done on the next edge, and remain in IDLE. Latency is 1 cycle and busy stays 0.
REQ-016 IDLE, start=1, mode=0: SHALL latch value and dots_in, clear the BCD accumulator, load iteration counter = 0, and enter CONVERT. busy=1 from the next cycle.
REQ-017 CONVERT: SHALL perform one double-dabble step per cycle: add 3 to each BCD digit >= 5, then shift left one bit, taking in the operand MSB. After 32 steps (counter 31) the FSM SHALL enter FINISH.
REQ-018 FINISH: SHALL update the outputs from the accumulator, pulse done for 1 cycle, drop busy, and return to IDLE. done SHALL be visible exactly 34 cycles after the edge that sampled start.
REQ-019 Overflow: if the latched value > 99_999_999, FINISH SHALL set ovf=1, every display digit = 4'hE, and en_out = 8'hFF. BCD digits above digit 7 SHALL be discarded.
REQ-020 Blanking (BLANK_LEADING=1, ovf=0): en_out[i] SHALL be 1 iff i=0 or some digit j>=i is nonzero. Value 0 gives en_out = 8'h01. Hex mode SHALL use the same rule.
REQ-021 start while busy=1 or in FINISH SHALL be ignored, with no queuing. Changes to value, mode or dots_in after sampling SHALL have no effect on the conversion in progress.
REQ-022 display, en_out, dots and ovf SHALL hold their last values between done pulses, and SHALL never show intermediate accumulator contents.
REQ-023 start held high continuously SHALL restart from IDLE immediately after each done: decimal back-to-back period is 34 cycles; hex mode loads every cycle.

Reset
REQ-024 clr_n=0 SHALL asynchronously force: FSM=IDLE, counter=0, display all 4'h0, en_out=8'h01, dots=8'h00, busy=0, done=0, ovf=0.
REQ-025 Reset during CONVERT SHALL abort the conversion with no done pulse. The first start after release SHALL behave as from power-up.

Structure
REQ-026 The FSM state enum, NUM_DIGITS=8, CONV_STEPS=32 and DEC_MAX=32'd99_999_999 SHALL live in a shared package, display_pkg.
REQ-027 The per-digit "add 3 if >= 5" correction SHALL be a combinational sub-module, bcd_adj4, instantiated 8 times. All other logic is flat.

Verification
REQ-028 Decimal 12345678 -> done at cycle 34; display = 1,2,3,4,5,6,7,8 (msd..lsd); en_out=8'hFF; ovf=0.
REQ-029 Decimal 0, then decimal 907 -> display 0 with en_out=8'h01; then 9,0,7 in low digits with en_out=8'h07.
REQ-030 Decimal 32'hFFFF_FFFF -> ovf=1, all digits 4'hE, en_out=8'hFF. Then decimal 99_999_999 -> ovf=0, all nines.
REQ-031 Hex 32'h00AB_C0DE, dots_in=8'h10 -> done 1 cycle later; display = 0,0,A,B,C,0,D,E; en_out=8'h3F; dots=8'h10.
REQ-032 start pulse mid-CONVERT with a different value -> ignored; result is the first value. clr_n low at step 15 -> no done, outputs at reset values, next conversion correct.
